// File: rtl/ws2812_multi_ctrl.sv
// ----------------------------------------------------------------------------
// ws2812_multi_ctrl
//   Multi-channel WS2812 LED string controller with an Avalon-MM slave port.
//   CH_NUM strings are driven in lock-step from a per-channel colour RAM.
//   Frame length, auto-refresh, sticky DONE and auto-incrementing DATA writes
//   are software controlled through a small register file.
//
// Ports
//   s_clk, s_reset_n      system clock, asynchronous active-low reset
//   s_address[2:0]        register word address
//   s_write_en/_data      write strobe and 32-bit write data
//   s_read_en/_data       read strobe and registered read data (1-cycle latency)
//   exp_dout[CH_NUM-1:0]  serial WS2812 data, bit c drives string c
//   irq                   level interrupt, DONE & IRQ_EN
//
// Register map
//   0 CTRL   : [0] START (pulse, reads 0), [1] AUTO, [2] IRQ_EN
//   1 STATUS : [0] BUSY (RO), [1] DONE (sticky, write 1 clears)
//   2 ADDR   : [ADDR_BIT-1:0] LED index, [18:16] channel
//   3 DATA   : write GRB[23:0] to RAM[ch][idx], idx auto-increments; reads ADDR
//   4 COUNT  : LEDs per frame, 0 or > LED_NUM means LED_NUM
// ----------------------------------------------------------------------------
module ws2812_multi_ctrl #(
  parameter int LED_NUM = 32,
  parameter int CH_NUM  = 2,
  parameter int BIT_CYC = 63,
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40,
  parameter int RST_CYC = 2500
) (
  input  logic              s_clk,
  input  logic              s_reset_n,
  input  logic [2:0]        s_address,
  input  logic              s_write_en,
  input  logic [31:0]       s_write_data,
  input  logic              s_read_en,
  output logic [31:0]       s_read_data,
  output logic [CH_NUM-1:0] exp_dout,
  output logic              irq
);

  localparam int ADDR_BIT = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam int CH_BIT   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int CYC_MAX  = (BIT_CYC > RST_CYC) ? BIT_CYC : RST_CYC;
  localparam int CYC_W    = $clog2(CYC_MAX + 1);

  localparam logic [ADDR_BIT:0]   LED_NUM_L = (ADDR_BIT + 1)'(LED_NUM);
  localparam logic [15:0]         LED_NUM_C = 16'(LED_NUM);
  localparam logic [3:0]          CH_NUM_L  = 4'(CH_NUM);
  localparam logic [ADDR_BIT-1:0] IDX_LAST  = ADDR_BIT'(LED_NUM - 1);
  localparam logic [CYC_W-1:0]    BIT_LAST  = CYC_W'(BIT_CYC - 1);
  localparam logic [CYC_W-1:0]    RST_LAST  = CYC_W'(RST_CYC - 1);
  localparam logic [CYC_W-1:0]    T0H_L     = CYC_W'(T0H_CYC);
  localparam logic [CYC_W-1:0]    T1H_L     = CYC_W'(T1H_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_BIT   = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // Register file
  logic                         auto_q, auto_d;
  logic                         irq_en_q, irq_en_d;
  logic                         done_q, done_d;
  logic [ADDR_BIT-1:0]          idx_q, idx_d;
  logic [2:0]                   ch_q, ch_d;
  // Held wider than the LED field so out-of-range values are seen as such
  // instead of aliasing onto a small count.
  logic [15:0]                  count_q, count_d;

  // Frame engine
  state_t                       state_q, state_d;
  logic [ADDR_BIT-1:0]          led_q, led_d;
  logic [4:0]                   bit_q, bit_d;
  logic [CYC_W-1:0]             cyc_q, cyc_d;
  logic [ADDR_BIT:0]            frame_cnt_q, frame_cnt_d;
  logic [CH_NUM-1:0][23:0]      shift_q, shift_d;

  // Registered outputs
  logic [CH_NUM-1:0]            dout_q, dout_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic                         irq_q, irq_d;

  logic [23:0]                  ram_q [CH_NUM][LED_NUM];

  logic                         wr_ctrl_s, wr_status_s, wr_addr_s, wr_data_s, wr_count_s;
  logic                         start_ok_s, ram_we_s, busy_s, done_set_s, last_led_s;
  logic [ADDR_BIT:0]            eff_count_s;
  logic [31:0]                  rd_mux_s, addr_reg_s;
  logic                         unused_s;

  assign wr_ctrl_s   = s_write_en && (s_address == 3'd0);
  assign wr_status_s = s_write_en && (s_address == 3'd1);
  assign wr_addr_s   = s_write_en && (s_address == 3'd2);
  assign wr_data_s   = s_write_en && (s_address == 3'd3);
  assign wr_count_s  = s_write_en && (s_address == 3'd4);

  assign busy_s     = (state_q != ST_IDLE);
  // START is only honoured while idle; a START during a frame is dropped.
  assign start_ok_s = wr_ctrl_s && s_write_data[0] && !busy_s;
  // Writes to a non-existent channel (or index) are dropped, the index still advances.
  assign ram_we_s   = wr_data_s && ({1'b0, ch_q} < CH_NUM_L) && ({1'b0, idx_q} < LED_NUM_L);

  assign eff_count_s = ((count_q == 16'd0) || (count_q > LED_NUM_C)) ? LED_NUM_L
                                                                      : count_q[ADDR_BIT:0];
  assign last_led_s  = ({1'b0, led_q} == (frame_cnt_q - {{ADDR_BIT{1'b0}}, 1'b1}));

  assign unused_s = ^s_write_data[31:24];

  // Colour RAM write port; contents are not reset.
  always_ff @(posedge s_clk) begin
    if (ram_we_s) begin
      ram_q[ch_q[CH_BIT-1:0]][idx_q] <= s_write_data[23:0];
    end
  end

  // Register-file next state: control bits, address pointer, count, sticky DONE, irq.
  always_comb begin
    auto_d   = auto_q;
    irq_en_d = irq_en_q;
    idx_d    = idx_q;
    ch_d     = ch_q;
    count_d  = count_q;
    done_d   = done_q;

    if (wr_ctrl_s) begin
      auto_d   = s_write_data[1];
      irq_en_d = s_write_data[2];
    end else begin
      auto_d   = auto_q;
      irq_en_d = irq_en_q;
    end

    if (wr_addr_s) begin
      idx_d = s_write_data[ADDR_BIT-1:0];
      ch_d  = s_write_data[18:16];
    end else if (wr_data_s) begin
      idx_d = (idx_q >= IDX_LAST) ? {ADDR_BIT{1'b0}} : idx_q + {{(ADDR_BIT-1){1'b0}}, 1'b1};
      ch_d  = ch_q;
    end else begin
      idx_d = idx_q;
      ch_d  = ch_q;
    end

    if (wr_count_s) begin
      count_d = s_write_data[15:0];
    end else begin
      count_d = count_q;
    end

    // Frame-end set has priority over a software clear in the same cycle.
    if (done_set_s) begin
      done_d = 1'b1;
    end else if (start_ok_s) begin
      done_d = 1'b0;
    end else if (wr_status_s && s_write_data[1]) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end

    irq_d = done_d & irq_en_d;
  end

  // Read mux and read-data hold.
  always_comb begin
    rd_mux_s   = 32'd0;
    addr_reg_s = 32'd0;
    addr_reg_s[18:16]        = ch_q;
    addr_reg_s[ADDR_BIT-1:0] = idx_q;
    case (s_address)
      3'd0:    rd_mux_s = {29'd0, irq_en_q, auto_q, 1'b0};
      3'd1:    rd_mux_s = {30'd0, done_q, busy_s};
      3'd2:    rd_mux_s = addr_reg_s;
      3'd3:    rd_mux_s = addr_reg_s;
      3'd4:    rd_mux_s = {16'd0, count_q};
      default: rd_mux_s = 32'd0;
    endcase
    if (s_read_en) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Frame FSM next state plus serial output generation.
  always_comb begin
    state_d     = state_q;
    led_d       = led_q;
    bit_d       = bit_q;
    cyc_d       = cyc_q;
    frame_cnt_d = frame_cnt_q;
    shift_d     = shift_q;
    done_set_s  = 1'b0;
    dout_d      = {CH_NUM{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_d     = ST_LOAD;
          led_d       = {ADDR_BIT{1'b0}};
          frame_cnt_d = eff_count_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // The RAM read is captured straight into the shifters, so a DATA
        // write to this LED in this cycle misses the current frame.
        for (int c = 0; c < CH_NUM; c++) begin
          shift_d[c] = ram_q[CH_BIT'(c)][led_q];
        end
        bit_d   = 5'd23;
        cyc_d   = {CYC_W{1'b0}};
        state_d = ST_BIT;
      end
      ST_BIT: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = {CYC_W{1'b0}};
          for (int c = 0; c < CH_NUM; c++) begin
            shift_d[c] = {shift_q[c][22:0], 1'b0};
          end
          if (bit_q == 5'd0) begin
            if (last_led_s) begin
              state_d = ST_LATCH;
            end else begin
              led_d   = led_q + {{(ADDR_BIT-1){1'b0}}, 1'b1};
              state_d = ST_LOAD;
            end
          end else begin
            bit_d = bit_q - 5'd1;
          end
        end else begin
          cyc_d = cyc_q + {{(CYC_W-1){1'b0}}, 1'b1};
        end
      end
      ST_LATCH: begin
        if (cyc_q == RST_LAST) begin
          cyc_d      = {CYC_W{1'b0}};
          done_set_s = 1'b1;
          if (auto_q) begin
            state_d     = ST_LOAD;
            led_d       = {ADDR_BIT{1'b0}};
            frame_cnt_d = eff_count_s;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cyc_d = cyc_q + {{(CYC_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Output is derived from next-state values so the registered pin lines
    // up with the state it belongs to (low during LOAD and LATCH).
    for (int c = 0; c < CH_NUM; c++) begin
      dout_d[c] = (state_d == ST_BIT) && (cyc_d < (shift_d[c][23] ? T1H_L : T0H_L));
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge s_clk or negedge s_reset_n) begin
    if (!s_reset_n) begin
      auto_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      idx_q       <= {ADDR_BIT{1'b0}};
      ch_q        <= 3'd0;
      count_q     <= 16'd0;
      state_q     <= ST_IDLE;
      led_q       <= {ADDR_BIT{1'b0}};
      bit_q       <= 5'd0;
      cyc_q       <= {CYC_W{1'b0}};
      frame_cnt_q <= {(ADDR_BIT+1){1'b0}};
      shift_q     <= {(CH_NUM*24){1'b0}};
      dout_q      <= {CH_NUM{1'b0}};
      rdata_q     <= 32'd0;
      irq_q       <= 1'b0;
    end else begin
      auto_q      <= auto_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      idx_q       <= idx_d;
      ch_q        <= ch_d;
      count_q     <= count_d;
      state_q     <= state_d;
      led_q       <= led_d;
      bit_q       <= bit_d;
      cyc_q       <= cyc_d;
      frame_cnt_q <= frame_cnt_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end

  assign s_read_data = rdata_q;
  assign exp_dout    = dout_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_ws2812_multi_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ws2812_multi_ctrl
//   Directed/random bench for ws2812_multi_ctrl. A reference model holds the
//   colour RAM and turns a frame request into the expected per-cycle serial
//   waveform (LOAD gap, 24 MSB-first bit cells, latch gap), plus the DONE/irq
//   level. Outputs are sampled 1 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_ws2812_multi_ctrl;

  localparam int LN = 4;
  localparam int CN = 2;
  localparam int BC = 10;
  localparam int T0 = 3;
  localparam int T1 = 7;
  localparam int RC = 20;

  logic          s_clk = 1'b0;
  logic          s_reset_n;
  logic [2:0]    s_address;
  logic          s_write_en;
  logic [31:0]   s_write_data;
  logic          s_read_en;
  logic [31:0]   s_read_data;
  logic [CN-1:0] exp_dout;
  logic          irq;

  ws2812_multi_ctrl #(
    .LED_NUM(LN), .CH_NUM(CN), .BIT_CYC(BC),
    .T0H_CYC(T0), .T1H_CYC(T1), .RST_CYC(RC)
  ) dut (
    .s_clk       (s_clk),
    .s_reset_n   (s_reset_n),
    .s_address   (s_address),
    .s_write_en  (s_write_en),
    .s_write_data(s_write_data),
    .s_read_en   (s_read_en),
    .s_read_data (s_read_data),
    .exp_dout    (exp_dout),
    .irq         (irq)
  );

  always #5 s_clk = ~s_clk;

  typedef struct packed {
    logic [1:0] dout;
    logic       last;
  } ent_t;

  typedef struct packed {
    int          at;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] data;
  } inj_t;

  ent_t        exp_q[$];
  inj_t        inj_q[$];
  logic [23:0] m_ram [CN][LN];
  int          m_idx = 0;
  int          m_ch  = 0;
  logic        done_m = 1'b0;
  logic        irq_en_m = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Model: expected waveform of one frame appended to exp_q.
  function automatic void add_frame(input int cnt);
    int   eff;
    ent_t e;
    eff = (cnt == 0 || cnt > LN) ? LN : cnt;
    for (int led = 0; led < eff; led++) begin
      e.dout = 2'b00;
      e.last = 1'b0;
      exp_q.push_back(e);
      for (int b = 23; b >= 0; b--) begin
        for (int k = 0; k < BC; k++) begin
          for (int c = 0; c < CN; c++) begin
            e.dout[c] = (k < (m_ram[c][led][b] ? T1 : T0));
          end
          e.last = 1'b0;
          exp_q.push_back(e);
        end
      end
    end
    for (int k = 0; k < RC; k++) begin
      e.dout = 2'b00;
      e.last = (k == RC - 1);
      exp_q.push_back(e);
    end
  endfunction

  function automatic void add_idle(input int n);
    ent_t e;
    e.dout = 2'b00;
    e.last = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endfunction

  function automatic void add_inj(input int at, input logic rd, input logic [2:0] a,
                                  input logic [31:0] d);
    inj_t j;
    j.at = at; j.rd = rd; j.addr = a; j.data = d;
    inj_q.push_back(j);
  endfunction

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    s_address = a; s_write_data = d; s_write_en = 1'b1;
    @(posedge s_clk); #1;
    s_write_en = 1'b0;
    case (a)
      3'd0: irq_en_m = d[2];
      3'd1: if (d[1]) done_m = 1'b0;
      3'd2: begin m_idx = int'(d[1:0]); m_ch = int'(d[18:16]); end
      3'd3: begin
        if (m_ch < CN) m_ram[m_ch][m_idx] = d[23:0];
        m_idx = (m_idx + 1) % LN;
      end
      default: ;
    endcase
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] expv, input string tag);
    s_address = a; s_read_en = 1'b1;
    @(posedge s_clk); #1;
    s_read_en = 1'b0;
    check(tag, s_read_data, expv);
  endtask

  // Plays the injections (START first at step 0) and compares every cycle.
  task automatic run_check(input string tag);
    inj_t cur;
    logic have;
    for (int n = 0; n < exp_q.size(); n++) begin
      have = 1'b0;
      foreach (inj_q[i]) if (inj_q[i].at == n) begin cur = inj_q[i]; have = 1'b1; end
      if (have) begin
        s_address = cur.addr;
        if (cur.rd) s_read_en = 1'b1;
        else begin s_write_en = 1'b1; s_write_data = cur.data; end
      end
      @(posedge s_clk); #1;
      s_write_en = 1'b0;
      s_read_en  = 1'b0;
      if (have && !cur.rd) begin
        if (cur.addr == 3'd0) begin
          irq_en_m = cur.data[2];
          if (cur.data[0] && n == 0) done_m = 1'b0;
        end
        if (cur.addr == 3'd1 && cur.data[1]) done_m = 1'b0;
      end
      if (n > 0 && exp_q[n-1].last) done_m = 1'b1;
      if (have && cur.rd) check({tag, "_read"}, s_read_data, cur.data);
      check({tag, "_dout"}, {30'd0, exp_dout}, {30'd0, exp_q[n].dout});
      check({tag, "_irq"}, {31'd0, irq}, {31'd0, done_m & irq_en_m});
    end
    exp_q.delete();
    inj_q.delete();
  endtask

  initial begin
    s_reset_n = 1'b0; s_address = 3'd0; s_write_en = 1'b0;
    s_write_data = 32'd0; s_read_en = 1'b0;
    repeat (3) @(posedge s_clk);
    #1;
    check("rst_dout", {30'd0, exp_dout}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata", s_read_data, 32'd0);
    s_reset_n = 1'b1;
    @(posedge s_clk); #1;
    rd(3'd0, 32'd0, "rst_ctrl");
    rd(3'd1, 32'd0, "rst_status");
    rd(3'd2, 32'd0, "rst_addr");
    rd(3'd4, 32'd0, "rst_count");

    // Random colours in every slot of both channels.
    for (int c = 0; c < CN; c++) begin
      wr(3'd2, 32'(c) << 16);
      for (int i = 0; i < LN; i++) wr(3'd3, $urandom & 32'h00FF_FFFF);
    end

    // 1: basic two-LED frame, DONE 503 cycles after START
    wr(3'd2, 32'd0);
    wr(3'd3, 32'h00FF_0000);
    wr(3'd3, 32'h0000_0001);
    wr(3'd4, 32'd2);
    add_inj(0, 1'b0, 3'd0, 32'h5);
    add_inj(1, 1'b1, 3'd1, 32'h1);
    add_inj(502, 1'b1, 3'd1, 32'h1);
    add_inj(503, 1'b1, 3'd1, 32'h2);
    add_frame(2);
    add_idle(5);
    run_check("basic");

    // 2: parallel channels, ch1 alternating pattern
    wr(3'd2, 32'h0001_0000);
    wr(3'd3, 32'h00AA_AAAA);
    wr(3'd4, 32'd1);
    add_inj(0, 1'b0, 3'd0, 32'h5);
    add_frame(1);
    add_idle(3);
    run_check("par");

    // 3: index wrap, ADDR readback, write to missing channel dropped
    wr(3'd2, 32'd3);
    wr(3'd3, $urandom & 32'h00FF_FFFF);
    wr(3'd3, $urandom & 32'h00FF_FFFF);
    rd(3'd3, 32'h0000_0001, "wrap_addr");
    wr(3'd2, 32'h0005_0002);
    wr(3'd3, 32'h0012_3456);
    rd(3'd2, 32'h0005_0003, "badch_addr");

    // 4: COUNT=0 -> full string, START mid-frame ignored
    wr(3'd4, 32'd0);
    add_inj(0, 1'b0, 3'd0, 32'h5);
    add_inj(300, 1'b0, 3'd0, 32'h5);
    add_inj(984, 1'b1, 3'd1, 32'h1);
    add_inj(985, 1'b1, 3'd1, 32'h2);
    add_frame(0);
    add_idle(4);
    run_check("cnt0");

    // 4b: COUNT=9 -> full string, fresh random colours
    for (int c = 0; c < CN; c++) begin
      wr(3'd2, 32'(c) << 16);
      for (int i = 0; i < LN; i++) wr(3'd3, $urandom & 32'h00FF_FFFF);
    end
    wr(3'd4, 32'd9);
    add_inj(0, 1'b0, 3'd0, 32'h5);
    add_inj(985, 1'b1, 3'd1, 32'h2);
    add_frame(9);
    add_idle(4);
    run_check("cnt9");

    // 5: auto refresh, set beats clear, clear later works, AUTO off ends run
    wr(3'd4, 32'd1);
    add_inj(0, 1'b0, 3'd0, 32'h7);
    add_inj(100, 1'b1, 3'd1, 32'h1);
    add_inj(261, 1'b0, 3'd1, 32'h2);
    add_inj(262, 1'b1, 3'd1, 32'h3);
    add_inj(300, 1'b0, 3'd0, 32'h4);
    add_inj(400, 1'b0, 3'd1, 32'h2);
    add_inj(523, 1'b1, 3'd1, 32'h2);
    add_frame(1);
    add_frame(1);
    add_idle(5);
    run_check("auto");

    // 6: reset while a '1' bit is high
    wr(3'd2, 32'd0);
    wr(3'd3, 32'h00FF_FFFF);
    add_inj(0, 1'b0, 3'd0, 32'h5);
    add_frame(1);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    run_check("prerst");
    s_reset_n = 1'b0;
    #1;
    check("arst_dout", {30'd0, exp_dout}, 32'd0);
    check("arst_irq", {31'd0, irq}, 32'd0);
    check("arst_rdata", s_read_data, 32'd0);
    @(posedge s_clk); #1;
    s_reset_n = 1'b1;
    rd(3'd1, 32'd0, "post_status");
    rd(3'd0, 32'd0, "post_ctrl");
    repeat (5) @(posedge s_clk);
    #1;
    check("post_dout", {30'd0, exp_dout}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
